// File: rtl/exit_monitor.sv
// exit_monitor: watches the CPU exit flag, counts RUN cycles, latches
// pass/fail/timeout and drives registered status flags plus an LED pattern.
module exit_monitor #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter int unsigned BLINK_W   = 24,
    parameter logic [2:0]  PASS_CODE = 3'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exit,
    input  logic [2:0]       gp,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [2:0]       gp_q,
    output logic [CNT_W-1:0] cycles,
    output logic             halt,
    output logic [3:0]       led
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cycles_next;
    logic [2:0]         gp_next;
    logic [BLINK_W-1:0] blink_cnt;
    logic [BLINK_W-1:0] blink_next;
    logic               blink;
    logic [3:0]         led_next;

    // Next-state, cycle counter and captured-gp logic.
    always_comb begin
        state_next  = state;
        cycles_next = cycles;
        gp_next     = gp_q;
        case (state)
            S_RUN: begin
                if (exit) begin
                    gp_next    = gp;
                    state_next = (gp == PASS_CODE) ? S_PASS : S_FAIL;
                end else if (cycles == TO_LAST) begin
                    cycles_next = TO_VAL;
                    state_next  = S_TIMEOUT;
                end else begin
                    cycles_next = cycles + 1'b1;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // LED pattern from next-state values so the registered led lines up with state.
    always_comb begin
        blink_next = blink_cnt + 1'b1;
        blink      = blink_next[BLINK_W-1];
        led_next   = 4'b0000;
        case (state_next)
            S_RUN:     led_next = {3'b000, blink};
            S_PASS:    led_next = {1'b1, gp_next};
            S_FAIL:    led_next = {blink, gp_next};
            S_TIMEOUT: led_next = {4{blink}};
            default:   led_next = 4'b0000;
        endcase
    end

    // State register and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            cycles    <= '0;
            gp_q      <= '0;
            blink_cnt <= '0;
        end else begin
            state     <= state_next;
            cycles    <= cycles_next;
            gp_q      <= gp_next;
            blink_cnt <= blink_next;
        end
    end

    // Registered status flags and LED output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            halt    <= 1'b0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
            led     <= '0;
        end else begin
            done    <= (state_next != S_RUN);
            halt    <= (state_next != S_RUN);
            pass    <= (state_next == S_PASS);
            fail    <= (state_next == S_FAIL);
            timeout <= (state_next == S_TIMEOUT);
            led     <= led_next;
        end
    end

endmodule

// File: tb/tb_exit_monitor.sv
// Scoreboard bench for exit_monitor: stimulus pushes expected terminal
// results, a monitor pops and compares whenever done rises.
module tb_exit_monitor;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 20;
    localparam int BLINK_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             exit = 1'b0;
    logic [2:0]       gp = 3'd0;
    logic             done, pass, fail, timeout, halt;
    logic [2:0]       gp_q;
    logic [CNT_W-1:0] cycles;
    logic [3:0]       led;

    exit_monitor #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .BLINK_W  (BLINK_W),
        .PASS_CODE(3'd1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .exit   (exit),
        .gp     (gp),
        .done   (done),
        .pass   (pass),
        .fail   (fail),
        .timeout(timeout),
        .gp_q   (gp_q),
        .cycles (cycles),
        .halt   (halt),
        .led    (led)
    );

    always #5 clk = ~clk;

    // Reference blink counter: counts edges since reset release.
    logic [BLINK_W-1:0] tb_blink;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_blink <= '0;
        else        tb_blink <= tb_blink + 1'b1;
    end

    typedef struct {
        string      name;
        logic       p, f, t;
        logic [2:0] g;
        logic [7:0] c;
        int         led_mode;   // 0 fixed, 1 {blink,gp_q}, 2 {4{blink}}
        logic [3:0] led_fix;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_assert++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    function automatic logic [3:0] exp_led(input int mode, input logic [3:0] fix);
        logic b;
        b = tb_blink[BLINK_W-1];
        case (mode)
            1:       exp_led = {b, fix[2:0]};
            2:       exp_led = {4{b}};
            default: exp_led = fix;
        endcase
    endfunction

    // Monitor: compare against the scoreboard head on each rising done.
    logic done_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no result at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_pass"},    pass,    e.p);
                chk({e.name, "_fail"},    fail,    e.f);
                chk({e.name, "_timeout"}, timeout, e.t);
                chk({e.name, "_halt"},    halt,    1);
                chk({e.name, "_gp_q"},    gp_q,    e.g);
                chk({e.name, "_cycles"},  cycles,  e.c);
                chk({e.name, "_led"},     led,     exp_led(e.led_mode, e.led_fix));
            end
        end
        done_prev = done;
    end

    task automatic push(input string name, input logic p, input logic f, input logic t,
                        input logic [2:0] g, input logic [7:0] c, input int mode,
                        input logic [3:0] fix);
        exp_t e;
        e.name = name; e.p = p; e.f = f; e.t = t; e.g = g; e.c = c;
        e.led_mode = mode; e.led_fix = fix;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s_no_done: got pending=%0d expected 0 within %0d cycles",
                     name, sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fire(input logic [2:0] g);
        exit = 1'b1;
        gp   = g;
        @(negedge clk);
        exit = 1'b0;
        gp   = 3'd0;
    endtask

    task automatic check_blink(input string name, input logic [3:0] fix, input int mode);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk(name, led, exp_led(mode, fix));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_led", led, 0);
        chk("rst_gp_q", gp_q, 0);

        // 1: pass after 5 RUN edges, sticky for 50 cycles
        reset_release();
        repeat (5) @(negedge clk);
        push("t1", 1, 0, 0, 3'd1, 8'd5, 0, 4'b1001);
        fire(3'd1);
        wait_drain("t1", 5);
        repeat (50) @(negedge clk);
        chk("t1_sticky_pass", {done, halt, pass, fail, timeout}, 5'b11100);
        chk("t1_sticky_cycles", cycles, 5);
        chk("t1_sticky_led", led, 4'b1001);

        // 2: fail with gp=5 after 7 edges, led[3] blinks
        reset_release();
        repeat (7) @(negedge clk);
        push("t2", 0, 1, 0, 3'd5, 8'd7, 1, 4'b0101);
        fire(3'd5);
        wait_drain("t2", 5);
        check_blink("t2_led_blink", 4'b0101, 1);
        chk("t2_cycles_frozen", cycles, 7);

        // 3: no exit -> timeout at edge 20
        reset_release();
        repeat (19) @(negedge clk);
        chk("t3_not_done_at_19", {done, cycles}, {1'b0, 8'd19});
        push("t3", 0, 0, 1, 3'd0, 8'd20, 2, 4'b0000);
        wait_drain("t3", 5);
        check_blink("t3_led_blink", 4'b0000, 2);
        chk("t3_cycles_frozen", cycles, 20);

        // 4: exit on the same edge as timeout boundary -> exit wins
        reset_release();
        repeat (19) @(negedge clk);
        push("t4", 1, 0, 0, 3'd1, 8'd19, 0, 4'b1001);
        fire(3'd1);
        wait_drain("t4", 5);
        repeat (5) @(negedge clk);
        chk("t4_no_timeout", {timeout, cycles}, {1'b0, 8'd19});

        // 5: later exit ignored, async reset mid-cycle, then fail
        reset_release();
        repeat (2) @(negedge clk);
        push("t5a", 1, 0, 0, 3'd1, 8'd2, 0, 4'b1001);
        fire(3'd1);
        wait_drain("t5a", 5);
        fire(3'd2);
        repeat (3) @(negedge clk);
        chk("t5_ignore_exit", {pass, fail, gp_q, cycles}, {1'b1, 1'b0, 3'd1, 8'd2});
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_reset", {done, halt, pass, fail, timeout, gp_q, cycles, led},
            '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push("t5b", 0, 1, 0, 3'd2, 8'd3, 1, 4'b0010);
        fire(3'd2);
        wait_drain("t5b", 5);

        // 6: exit held high through reset release
        @(negedge clk);
        rst_n = 1'b0;
        exit  = 1'b1;
        gp    = 3'd1;
        push("t6", 1, 0, 0, 3'd1, 8'd0, 0, 4'b1001);
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain("t6", 5);
        exit = 1'b0;
        gp   = 3'd0;

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
